serial_sub_ctrl: RTL and testbench

- Nibble-serial sequencer that computes a wide subtraction a - b - borrowIn on one shared 4-bit `parallel_sub` slice (ports a, b, borrowIn, diff, borrowOut).
- Processes one nibble per clock, LSB nibble first, and chains the borrow through a register.
- Uses a start/busy/done handshake so upstream logic can issue wide subtractions without replicating the slice.

---
 rtl/serial_sub_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// serial_sub_ctrl
// ----------------------------------------------------------------------------
// Nibble-serial subtractor. It computes diff = a - b - borrowIn (modulo 2^W,
// W = 4*NIBBLES) on a single shared 4-bit subtract slice. The slice handles
// one nibble per clock, starting with the least significant nibble, and the
// borrow is passed from nibble to nibble through a register.
//
// Handshake:
//   start  - request a subtraction. It is accepted in IDLE or DONE.
//   busy   - high for exactly NIBBLES cycles while nibbles are processed.
//   done   - one-cycle pulse. diff/borrowOut (and zero) are valid while it
//            is high.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   start      subtraction request
//   a, b       minuend / subtrahend (W bits), captured on an accepted start
//   borrowIn   initial borrow, captured on an accepted start
//   busy       processing indicator
//   done       result-valid pulse
//   diff       a - b - borrowIn modulo 2^W
//   borrowOut  1 iff a < b + borrowIn (unsigned)
//   zero       (only with SERIAL_SUB_ZERO_FLAG_EN) 1 iff diff == 0
//
// Optional feature macro: SERIAL_SUB_ZERO_FLAG_EN adds the zero output.
// ============================================================================
module serial_sub_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 borrowIn,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] diff,
   output logic                 borrowOut
`ifdef SERIAL_SUB_ZERO_FLAG_EN
   ,
   output logic                 zero
`endif
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          borrow_q, borrow_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          busy_d, done_d;
   logic [W-1:0]  diff_d;
   logic          borrow_out_d;

   logic [IW+1:0] bit_pos;
   logic [3:0]    slice_a, slice_b, slice_diff;
   logic          slice_borrow;
   logic [4:0]    slice_wide;

   // This is the shared 4-bit subtract slice. It takes the nibble chosen by
   // the index register. The extra top bit of the 5-bit difference is set
   // exactly when the nibble subtraction went negative, so that bit is the
   // borrow passed on to the next nibble.
   always_comb begin
      bit_pos      = {idx_q, 2'b00};
      slice_a      = a_q[bit_pos +: 4];
      slice_b      = b_q[bit_pos +: 4];
      slice_wide   = {1'b0, slice_a} - {1'b0, slice_b} - {4'b0000, borrow_q};
      slice_diff   = slice_wide[3:0];
      slice_borrow = slice_wide[4];
   end

   // This block computes the next state and the next values of all
   // registered outputs. A start is accepted in DONE just as in IDLE, so
   // operations can run back to back without an idle cycle. In RUN the
   // start input is ignored. diff keeps its old upper nibbles until the
   // slice reaches them.
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      borrow_d     = borrow_q;
      idx_d        = idx_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      diff_d       = diff;
      borrow_out_d = borrowOut;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = borrowIn;
               idx_d    = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            diff_d[bit_pos +: 4] = slice_diff;
            borrow_d             = slice_borrow;
            if (idx_q == LAST_IDX) begin
               state_d      = DONE;
               done_d       = 1'b1;
               borrow_out_d = slice_borrow;
            end else begin
               busy_d = 1'b1;
               idx_d  = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // This block holds the state register, the captured operands, the borrow
   // chain and the registered outputs. Reset clears all of them at once, so
   // an operation that is in progress is abandoned without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         borrow_q  <= 1'b0;
         idx_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         diff      <= '0;
         borrowOut <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         borrow_q  <= borrow_d;
         idx_q     <= idx_d;
         busy      <= busy_d;
         done      <= done_d;
         diff      <= diff_d;
         borrowOut <= borrow_out_d;
      end
   end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
   logic zacc_q, zacc_d;
   logic zero_d;

   // This block keeps a running "all nibbles so far were zero" flag. It is
   // set when an operation is accepted and cleared by any nonzero slice
   // result. The final nibble is folded in on the same edge that
   // publishes zero.
   always_comb begin
      zacc_d = zacc_q;
      zero_d = zero;
      if ((state_q == IDLE || state_q == DONE) && start) begin
         zacc_d = 1'b1;
      end else if (state_q == RUN) begin
         zacc_d = zacc_q & (slice_diff == 4'h0);
         if (idx_q == LAST_IDX) begin
            zero_d = zacc_d;
         end
      end
   end

   // This block registers the zero accumulator and the zero output. The
   // output holds its value until the next result is published.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zacc_q <= 1'b0;
         zero   <= 1'b0;
      end else begin
         zacc_q <= zacc_d;
         zero   <= zero_d;
      end
   end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// ============================================================================
// tb_serial_sub_ctrl
// ----------------------------------------------------------------------------
// Testbench for serial_sub_ctrl with NIBBLES=4. Expected results come from
// plain integer arithmetic on the operands (a - b - borrowIn) and from the
// fixed handshake timing (done NIBBLES+1 cycles after the accepting edge).
// ============================================================================
module tb_serial_sub_ctrl;

   localparam int NIBBLES = 4;
   localparam int LAT     = NIBBLES + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a, b;
   logic        borrowIn;
   logic        busy, done;
   logic [15:0] diff;
   logic        borrowOut;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
   logic        zero;
`endif

   int checks = 0;
   int errors = 0;

   // The clock has a 10 ns period. Inputs change and outputs are sampled
   // 1 ns after each rising edge.
   always #5 clk = ~clk;

   serial_sub_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .borrowIn  (borrowIn),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .borrowOut (borrowOut)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      ,
      .zero      (zero)
`endif
   );

   // Reference result: {borrow, diff} from integer subtraction. The borrow
   // is set when the true difference is negative.
   function automatic logic [16:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                           input logic bin);
      int          r;
      logic [16:0] res;
      r         = int'(x) - int'(y) - int'(bin);
      res[15:0] = r[15:0];
      res[16]   = (r < 0);
      return res;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation and waits, with a bound, for done. Operands are
   // scrambled after the accepting edge so that the captured copy is the
   // one being checked.
   task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic bin,
                        output logic [15:0] d, output logic bo, output logic z,
                        output int lat, output int busy_cycles);
      start    = 1'b1;
      a        = x;
      b        = y;
      borrowIn = bin;
      next_cycle();
      start    = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      borrowIn = 1'($urandom);
      lat         = 1;
      busy_cycles = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cycles++;
         next_cycle();
         lat++;
      end
      if (done !== 1'b1) lat = -1;
      d  = diff;
      bo = borrowOut;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      z  = zero;
`else
      z  = 1'b0;
`endif
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      borrowIn = 1'b0;
      next_cycle();
      next_cycle();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (diff !== 16'h0) begin errors++; $display("[TB] FAIL reset_diff: got %h expected 0000", diff); end
      checks++; if (borrowOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_borrow: got %b expected 0", borrowOut); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero: got %b expected 0", zero); end
`endif
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_basic();
      logic [15:0] d;
      logic        bo, z;
      int          lat, bc;
      do_op(16'h1234, 16'h0234, 1'b0, d, bo, z, lat, bc);
      checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (bc !== NIBBLES) begin errors++; $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", bc, NIBBLES); end
      checks++; if (d !== 16'h1000) begin errors++; $display("[TB] FAIL basic_diff: got %h expected 1000", d); end
      checks++; if (bo !== 1'b0) begin errors++; $display("[TB] FAIL basic_borrow: got %b expected 0", bo); end
      next_cycle();
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_underflow();
      logic [15:0] d, x, y;
      logic        bo, z, bin;
      logic [16:0] r;
      int          lat, bc;
      do_op(16'h0000, 16'h0001, 1'b0, d, bo, z, lat, bc);
      checks++; if (d !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_diff: got %h expected ffff", d); end
      checks++; if (bo !== 1'b1) begin errors++; $display("[TB] FAIL wrap_borrow: got %b expected 1", bo); end
      // Random sweep. Starts are issued sometimes from DONE and sometimes
      // after a gap from IDLE.
      for (int i = 0; i < 1000; i++) begin
         x   = 16'($urandom);
         y   = 16'($urandom);
         bin = 1'($urandom);
         if ($urandom_range(0, 1) == 1) next_cycle();
         do_op(x, y, bin, d, bo, z, lat, bc);
         r = ref_sub(x, y, bin);
         checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL sweep_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
         checks++; if (d !== r[15:0]) begin errors++; $display("[TB] FAIL sweep_diff[%0d]: %h-%h-%b got %h expected %h", i, x, y, bin, d, r[15:0]); end
         checks++; if (bo !== r[16]) begin errors++; $display("[TB] FAIL sweep_borrow[%0d]: %h-%h-%b got %b expected %b", i, x, y, bin, bo, r[16]); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
         checks++; if (z !== (r[15:0] == 16'h0)) begin errors++; $display("[TB] FAIL sweep_zero[%0d]: got %b expected %b", i, z, (r[15:0] == 16'h0)); end
`endif
      end
   endtask

   task automatic test_borrow_chain();
      logic [15:0] d;
      logic        bo, z;
      int          lat, bc;
      do_op(16'h0005, 16'h0005, 1'b1, d, bo, z, lat, bc);
      checks++; if (d !== 16'hFFFF) begin errors++; $display("[TB] FAIL chain_diff: got %h expected ffff", d); end
      checks++; if (bo !== 1'b1) begin errors++; $display("[TB] FAIL chain_borrow: got %b expected 1", bo); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      checks++; if (z !== 1'b0) begin errors++; $display("[TB] FAIL chain_zero: got %b expected 0", z); end
`endif
      do_op(16'hABCD, 16'hABCD, 1'b0, d, bo, z, lat, bc);
      checks++; if (d !== 16'h0000) begin errors++; $display("[TB] FAIL equal_diff: got %h expected 0000", d); end
      checks++; if (bo !== 1'b0) begin errors++; $display("[TB] FAIL equal_borrow: got %b expected 0", bo); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
      checks++; if (z !== 1'b1) begin errors++; $display("[TB] FAIL equal_zero: got %b expected 1", z); end
`endif
   endtask

   // start is held high while the operands change every cycle. Only the
   // operands present at the accepting edges (cycles 0 and 5) may matter.
   task automatic test_start_during_busy();
      logic [15:0] oa [0:10];
      logic [15:0] ob [0:10];
      logic        obin [0:10];
      logic [16:0] r;
      logic        exp_done, exp_busy;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) begin
            exp_done = (c % LAT == 0);
            exp_busy = (c % LAT != 0);
            checks++; if (done !== exp_done) begin errors++; $display("[TB] FAIL busy_start_done[c%0d]: got %b expected %b", c, done, exp_done); end
            checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL busy_start_busy[c%0d]: got %b expected %b", c, busy, exp_busy); end
            if (exp_done) begin
               r = ref_sub(oa[c-LAT], ob[c-LAT], obin[c-LAT]);
               checks++; if (diff !== r[15:0]) begin errors++; $display("[TB] FAIL busy_start_diff[c%0d]: got %h expected %h", c, diff, r[15:0]); end
               checks++; if (borrowOut !== r[16]) begin errors++; $display("[TB] FAIL busy_start_borrow[c%0d]: got %b expected %b", c, borrowOut, r[16]); end
            end
         end
         oa[c]    = 16'($urandom);
         ob[c]    = 16'($urandom);
         obin[c]  = 1'($urandom);
         a        = oa[c];
         b        = ob[c];
         borrowIn = obin[c];
         start    = (c < 10);
         next_cycle();
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      logic        bo, z;
      int          lat, bc;
      bit          saw_done;
      start    = 1'b1;
      a        = 16'hFFFF;
      b        = 16'h0001;
      borrowIn = 1'b0;
      next_cycle();
      start = 1'b0;
      next_cycle();
      next_cycle();
      // The slice is now working on nibble 2. Reset is asserted between
      // clock edges, so the outputs have to clear without any edge.
      #2 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
      checks++; if (diff !== 16'h0) begin errors++; $display("[TB] FAIL midrst_diff: got %h expected 0000", diff); end
      checks++; if (borrowOut !== 1'b0) begin errors++; $display("[TB] FAIL midrst_borrow: got %b expected 0", borrowOut); end
      next_cycle();
      next_cycle();
      rst      = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
         next_cycle();
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_done: got %b expected 0", saw_done); end
      do_op(16'hFFFF, 16'h0001, 1'b0, d, bo, z, lat, bc);
      checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (d !== 16'hFFFE) begin errors++; $display("[TB] FAIL midrst_diff_after: got %h expected fffe", d); end
      checks++; if (bo !== 1'b0) begin errors++; $display("[TB] FAIL midrst_borrow_after: got %b expected 0", bo); end
   endtask

   task automatic test_back_to_back();
      logic exp_done;
      next_cycle();
      start    = 1'b1;
      a        = 16'h8000;
      b        = 16'h0001;
      borrowIn = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         next_cycle();
         exp_done = (c == 5 || c == 10);
         checks++; if (done !== exp_done) begin errors++; $display("[TB] FAIL b2b_done[c%0d]: got %b expected %b", c, done, exp_done); end
         if (c == 5) begin
            checks++; if (diff !== 16'h7FFF) begin errors++; $display("[TB] FAIL b2b_diff1: got %h expected 7fff", diff); end
            checks++; if (borrowOut !== 1'b0) begin errors++; $display("[TB] FAIL b2b_borrow1: got %b expected 0", borrowOut); end
            a = 16'h0001;
            b = 16'h8000;
         end
         if (c == 6) start = 1'b0;
         if (c == 10) begin
            checks++; if (diff !== 16'h8001) begin errors++; $display("[TB] FAIL b2b_diff2: got %h expected 8001", diff); end
            checks++; if (borrowOut !== 1'b1) begin errors++; $display("[TB] FAIL b2b_borrow2: got %b expected 1", borrowOut); end
         end
      end
      start = 1'b0;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_borrow_chain();
      test_start_during_busy();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Overall time bound in case the design stops responding.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

endmodule
